// File: rtl/mesh_send_arbiter_pkg.sv
// Shared types and helpers for the mesh send arbiter.
package mesh_send_arbiter_pkg;

   typedef enum logic [1:0] {ArbIdle, ArbGrant, ArbGuard} arb_state_t;

   localparam int unsigned CountW = 32;

   function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
      return (v == '1) ? v : v + CountW'(1);
   endfunction

endpackage

// File: rtl/mesh_send_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = 2
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic              found_o,
   output logic [IdxW-1:0]   idx_o
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

   logic [IdxW-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = ptr_i;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
         cand = (cand == LastIdx) ? '0 : cand + IdxW'(1);
      end
   end

endmodule

// File: rtl/mesh_send_arbiter.sv
// Time-sliced round-robin arbiter for the shared mesh send resource, with a
// guard gap after every slot for channel reconfiguration.
module mesh_send_arbiter
   import mesh_send_arbiter_pkg::*;
#(
   parameter int unsigned N            = 2,
   parameter int unsigned SLOT_CYCLES  = 4,
   parameter int unsigned GUARD_CYCLES = 1,
   parameter int unsigned ID_W         = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arb_enable,
   input  logic [N*N-1:0]    request_to_send,
   output logic [N*N-1:0]    permission_granted_send,
   output logic              grant_valid,
   output logic [ID_W-1:0]   grant_id,
   output logic [CountW-1:0] grant_count
);

   localparam int unsigned     NUM_ROUTERS = N * N;
   localparam logic [ID_W-1:0] LastId      = ID_W'(NUM_ROUTERS - 1);

   if (SLOT_CYCLES < 1) begin : g_bad_slot
      $error("mesh_send_arbiter: SLOT_CYCLES must be >= 1");
   end

   arb_state_t             state_q;
   logic [NUM_ROUTERS-1:0] grant_q;
   logic                   valid_q;
   logic [ID_W-1:0]        id_q;
   logic [ID_W-1:0]        rr_ptr_q;
   logic [CountW-1:0]      count_q;
   logic [31:0]            slot_cnt_q;
   logic [31:0]            guard_cnt_q;

   logic                   pick_found;
   logic [ID_W-1:0]        pick_idx;
   logic                   slot_end;
   logic [ID_W-1:0]        next_ptr;

   rr_picker #(
      .NumReq (NUM_ROUTERS),
      .IdxW   (ID_W)
   ) u_picker (
      .req_i   (request_to_send),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Only the grantee's own request can cut a slot short.
   assign slot_end = (slot_cnt_q == '0) || !request_to_send[id_q];
   assign next_ptr = (id_q == LastId) ? '0 : id_q + ID_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ArbIdle;
         grant_q     <= '0;
         valid_q     <= 1'b0;
         id_q        <= '0;
         rr_ptr_q    <= '0;
         count_q     <= '0;
         slot_cnt_q  <= '0;
         guard_cnt_q <= '0;
      end else begin
         unique case (state_q)
            ArbIdle: begin
               if (arb_enable && pick_found) begin
                  grant_q    <= NUM_ROUTERS'(1) << pick_idx;
                  valid_q    <= 1'b1;
                  id_q       <= pick_idx;
                  count_q    <= sat_inc(count_q);
                  slot_cnt_q <= 32'(SLOT_CYCLES - 1);
                  state_q    <= ArbGrant;
               end
            end
            ArbGrant: begin
               if (slot_end) begin
                  grant_q  <= '0;
                  valid_q  <= 1'b0;
                  rr_ptr_q <= next_ptr;
                  if (GUARD_CYCLES > 0) begin
                     guard_cnt_q <= 32'(GUARD_CYCLES - 1);
                     state_q     <= ArbGuard;
                  end else begin
                     state_q <= ArbIdle;
                  end
               end else begin
                  slot_cnt_q <= slot_cnt_q - 32'd1;
               end
            end
            ArbGuard: begin
               if (guard_cnt_q == '0) begin
                  state_q <= ArbIdle;
               end else begin
                  guard_cnt_q <= guard_cnt_q - 32'd1;
               end
            end
            default: state_q <= ArbIdle;
         endcase
      end
   end

   assign permission_granted_send = grant_q;
   assign grant_valid             = valid_q;
   assign grant_id                = id_q;
   assign grant_count             = count_q;

endmodule

// File: tb/tb_mesh_send_arbiter.sv
// Bench for mesh_send_arbiter: two instances (guard 1 and guard 0) against a reference model.
module tb_mesh_send_arbiter;

   typedef struct packed {
      logic [3:0]  gnt;
      logic        vld;
      logic [1:0]  id;
      logic [31:0] cnt;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        arb_enable;
   logic [3:0]  req;

   logic [3:0]  gnt_a, gnt_b;
   logic        vld_a, vld_b;
   logic [1:0]  id_a, id_b;
   logic [31:0] cnt_a, cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   pair_t exp_q[$];

   // Reference model state; index 0 mirrors dut (guard 1), index 1 mirrors dut_g0.
   int          m_st[2];
   int          m_used[2];
   int          m_ptr[2];
   int          m_id[2];
   logic [3:0]  m_gnt[2];
   logic        m_vld[2];
   logic [31:0] m_cnt[2];

   always #5 clk = ~clk;

   mesh_send_arbiter #(
      .N            (2),
      .SLOT_CYCLES  (4),
      .GUARD_CYCLES (1)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .arb_enable              (arb_enable),
      .request_to_send         (req),
      .permission_granted_send (gnt_a),
      .grant_valid             (vld_a),
      .grant_id                (id_a),
      .grant_count             (cnt_a)
   );

   mesh_send_arbiter #(
      .N            (2),
      .SLOT_CYCLES  (4),
      .GUARD_CYCLES (0)
   ) dut_g0 (
      .clk                     (clk),
      .rst                     (rst),
      .arb_enable              (arb_enable),
      .request_to_send         (req),
      .permission_granted_send (gnt_b),
      .grant_valid             (vld_b),
      .grant_id                (id_b),
      .grant_count             (cnt_b)
   );

   task automatic model_step(input int v, input logic r, input logic en, input logic [3:0] rq);
      int guard;
      bit found;
      int c;
      guard = (v == 0) ? 1 : 0;
      if (r) begin
         m_st[v] = 0; m_used[v] = 0; m_ptr[v] = 0; m_id[v] = 0;
         m_gnt[v] = '0; m_vld[v] = 1'b0; m_cnt[v] = '0;
      end else if (m_st[v] == 0) begin
         found = 0;
         if (en) begin
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr[v] + k) % 4;
               if (!found && rq[c]) begin
                  found = 1;
                  m_id[v] = c;
               end
            end
         end
         if (found) begin
            m_gnt[v] = 4'b0001 << m_id[v];
            m_vld[v] = 1'b1;
            if (m_cnt[v] != 32'hFFFF_FFFF) m_cnt[v] = m_cnt[v] + 1;
            m_used[v] = 1;
            m_st[v] = 1;
         end
      end else if (m_st[v] == 1) begin
         if (m_used[v] == 4 || !rq[m_id[v]]) begin
            m_gnt[v] = '0;
            m_vld[v] = 1'b0;
            m_ptr[v] = (m_id[v] + 1) % 4;
            if (guard > 0) begin
               m_st[v] = 2;
               m_used[v] = 1;
            end else begin
               m_st[v] = 0;
            end
         end else begin
            m_used[v]++;
         end
      end else begin
         if (m_used[v] >= guard) m_st[v] = 0;
         else m_used[v]++;
      end
   endtask

   function automatic obs_t model_obs(input int v);
      return {m_gnt[v], m_vld[v], 2'(m_id[v]), m_cnt[v]};
   endfunction

   function automatic pair_t observe();
      return {gnt_a, vld_a, id_a, cnt_a, gnt_b, vld_b, id_b, cnt_b};
   endfunction

   // Drive one cycle of stimulus, queue the model's prediction, sample #1 after the edge.
   task automatic cycle(input logic r, input logic en, input logic [3:0] rq);
      rst = r;
      arb_enable = en;
      req = rq;
      for (int v = 0; v < 2; v++) model_step(v, r, en, rq);
      exp_q.push_back({model_obs(0), model_obs(1)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      pair_t got, e;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 4'b1111);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL reset[%0d]: got %h exp %h", i, got, e);
         end
      end
      n_cmp++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== 39'd0) begin
         n_bad++; $display("FAIL reset_zero: got %h exp 0", {gnt_a, vld_a, id_a, cnt_a});
      end
   endtask

   task automatic test_single_hold();
      logic [5:0] s[$];
      pair_t got, e;
      int hits = 0;
      s.push_back({2'b11, 4'b0000});
      repeat (7) s.push_back({2'b01, 4'b0100});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL single_hold[%0d]: got %h exp %h", i, got, e);
         end
         if (i < 7 && gnt_a == 4'b0100) hits++;
      end
      n_cmp++;
      if (hits !== 4) begin
         n_bad++; $display("FAIL single_hold_len: got %0d exp 4", hits);
      end
      n_cmp++;
      if ({gnt_a, cnt_a} !== {4'b0100, 32'd2}) begin
         n_bad++; $display("FAIL single_regrant: got %b/%0d exp 0100/2", gnt_a, cnt_a);
      end
   endtask

   task automatic test_all_request();
      logic [5:0] s[$];
      pair_t got, e;
      int seq[$];
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      logic prev = 1'b0;
      s.push_back({2'b11, 4'b1111});
      repeat (30) s.push_back({2'b01, 4'b1111});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL all_req[%0d]: got %h exp %h", i, got, e);
         end
         if (vld_a && !prev) seq.push_back(int'(id_a));
         prev = vld_a;
      end
      n_cmp++;
      if (seq.size() != 5) begin
         n_bad++; $display("FAIL all_req_count: got %0d exp 5", seq.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (seq[k] != exp_ord[k]) begin
               n_bad++; $display("FAIL all_req_order[%0d]: got %0d exp %0d", k, seq[k], exp_ord[k]);
            end
         end
      end
   endtask

   task automatic test_early_drop();
      logic [5:0] s[$];
      pair_t got, e;
      int hits = 0;
      s.push_back({2'b11, 4'b0000});
      repeat (3) s.push_back({2'b01, 4'b0010});
      repeat (3) s.push_back({2'b01, 4'b0100});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL early_drop[%0d]: got %h exp %h", i, got, e);
         end
         if (gnt_a == 4'b0010) hits++;
      end
      n_cmp++;
      if (hits !== 3) begin
         n_bad++; $display("FAIL early_drop_len: got %0d exp 3", hits);
      end
      n_cmp++;
      if ({gnt_a, id_a} !== {4'b0100, 2'd2}) begin
         n_bad++; $display("FAIL early_drop_next: got %b/%0d exp 0100/2", gnt_a, id_a);
      end
   endtask

   task automatic test_wrap();
      logic [5:0] s[$];
      pair_t got, e;
      s.push_back({2'b11, 4'b0000});
      s.push_back({2'b01, 4'b1000});
      repeat (3) s.push_back({2'b01, 4'b0101});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL wrap[%0d]: got %h exp %h", i, got, e);
         end
      end
      n_cmp++;
      if ({gnt_a, vld_a, id_a} !== {4'b0001, 1'b1, 2'd0}) begin
         n_bad++; $display("FAIL wrap_grant: got %b/%b/%0d exp 0001/1/0", gnt_a, vld_a, id_a);
      end
   endtask

   task automatic test_enable();
      logic [5:0] s[$];
      pair_t got, e;
      int hits = 0;
      logic [31:0] cnt_idle = '0;
      s.push_back({2'b11, 4'b1111});
      s.push_back({2'b01, 4'b1111});
      repeat (10) s.push_back({2'b00, 4'b1111});
      s.push_back({2'b01, 4'b1111});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL enable[%0d]: got %h exp %h", i, got, e);
         end
         if (i >= 1 && i <= 11 && vld_a) hits++;
         if (i == 11) cnt_idle = cnt_a;
      end
      n_cmp++;
      if (hits !== 4) begin
         n_bad++; $display("FAIL enable_slot_len: got %0d exp 4", hits);
      end
      n_cmp++;
      if (cnt_idle !== 32'd1) begin
         n_bad++; $display("FAIL enable_hold_count: got %0d exp 1", cnt_idle);
      end
      n_cmp++;
      if ({gnt_a, id_a, cnt_a} !== {4'b0010, 2'd1, 32'd2}) begin
         n_bad++; $display("FAIL enable_resume: got %b/%0d/%0d exp 0010/1/2", gnt_a, id_a, cnt_a);
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] s[$];
      pair_t got, e;
      logic [77:0] at_rst = '1;
      s.push_back({2'b11, 4'b1111});
      repeat (2) s.push_back({2'b01, 4'b1111});
      s.push_back({2'b11, 4'b1111});
      s.push_back({2'b01, 4'b1111});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL reset_mid[%0d]: got %h exp %h", i, got, e);
         end
         if (i == 3) at_rst = got;
      end
      n_cmp++;
      if (at_rst !== 78'd0) begin
         n_bad++; $display("FAIL reset_mid_zero: got %h exp 0", at_rst);
      end
      n_cmp++;
      if ({gnt_a, id_a, cnt_a} !== {4'b0001, 2'd0, 32'd1}) begin
         n_bad++; $display("FAIL reset_mid_regrant: got %b/%0d/%0d exp 0001/0/1", gnt_a, id_a, cnt_a);
      end
   endtask

   task automatic test_no_guard();
      logic [5:0] s[$];
      pair_t got, e;
      int gap = 0;
      s.push_back({2'b11, 4'b0000});
      repeat (7) s.push_back({2'b01, 4'b0011});
      foreach (s[i]) begin
         cycle(s[i][5], s[i][4], s[i][3:0]);
         got = observe(); e = exp_q.pop_front(); n_cmp++;
         if (got !== e || !$onehot0(got.a.gnt) || !$onehot0(got.b.gnt)) begin
            n_bad++; $display("FAIL no_guard[%0d]: got %h exp %h", i, got, e);
         end
         if (i >= 1 && i <= 5 && !vld_b) gap++;
         if (i == 6) begin
            n_cmp++;
            if ({gnt_b, id_b} !== {4'b0010, 2'd1}) begin
               n_bad++; $display("FAIL no_guard_second: got %b/%0d exp 0010/1", gnt_b, id_b);
            end
         end
      end
      n_cmp++;
      if (gap !== 1) begin
         n_bad++; $display("FAIL no_guard_gap: got %0d exp 1", gap);
      end
   endtask

   initial begin
      rst = 1'b1;
      arb_enable = 1'b0;
      req = '0;
      test_reset();
      test_single_hold();
      test_all_request();
      test_early_drop();
      test_wrap();
      test_enable();
      test_reset_mid();
      test_no_guard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
